mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_pkg.sv | 40 ++++
 rtl/booth_r4_core.sv | 75 +++++++
 rtl/mul_share_arbiter.sv | 125 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types/constants for the shared radix-4 Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_op_t;

  // Triplet is {y[2k+1], y[2k], y[2k-1]}
  function automatic booth_op_t booth_decode(input logic [2:0] trip);
    booth_op_t op;
    case (trip)
      3'b001, 3'b010: op = BOOTH_POS1;
      3'b011:         op = BOOTH_POS2;
      3'b100:         op = BOOTH_NEG2;
      3'b101, 3'b110: op = BOOTH_NEG1;
      default:        op = BOOTH_ZERO;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_core.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_core
// Purpose  : Iterative radix-4 Booth multiplier, one digit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_core
  import mul_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int STEPS = W / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic            r_run;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_mcand;
  logic [W:0]      r_mplr;
  logic [2*W-1:0]  r_acc;

  booth_op_t       w_op;
  logic [2*W-1:0]  w_term;
  logic [2*W-1:0]  w_acc_next;

  always_comb begin
    w_op = booth_decode(r_mplr[2:0]);
    case (w_op)
      BOOTH_POS1: w_term = r_mcand;
      BOOTH_POS2: w_term = r_mcand << 1;
      BOOTH_NEG1: w_term = -r_mcand;
      BOOTH_NEG2: w_term = -(r_mcand << 1);
      default:    w_term = '0;
    endcase
    w_acc_next = r_acc + w_term;
  end

  // prod is the post-step sum, valid in the cycle done is high
  assign done = r_run && (r_cnt == CW'(STEPS - 1));
  assign prod = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= {{W{x[W-1]}}, x};
      r_mplr  <= {y, 1'b0};
    end else if (r_run) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 2;
      r_mplr  <= {{2{r_mplr[W]}}, r_mplr[W:2]};
      r_cnt   <= r_cnt + 1'b1;
      if (done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin arbitration of NREQ requesters onto one Booth core.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int W    = W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_x,
  input  logic [NREQ*W-1:0]       req_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*W-1:0]          rsp_prod,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_owner;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*W-1:0]  r_rsp_prod;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [IDW:0]    w_idx;
  logic [IDW-1:0]  w_gnt_inc;
  logic            w_accept;
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_y;
  logic            w_core_done;
  logic [2*W-1:0]  w_core_prod;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign w_gnt_inc = ({1'b0, w_gnt} + 1'b1 == (IDW+1)'(NREQ)) ? '0 : w_gnt + 1'b1;
  assign w_x       = req_x[w_gnt*W +: W];
  assign w_y       = req_y[w_gnt*W +: W];

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)                   w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_core_done)                w_state_nxt = ST_DONE;
      ST_DONE: if (r_rsp_valid && rsp_ready)   w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rr_ptr <= w_gnt_inc;
        r_owner  <= w_gnt;
      end
      if (r_state == ST_BUSY && w_core_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_owner;
        r_rsp_prod  <= w_core_prod;
      end else if (r_state == ST_DONE && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  booth_r4_core #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (w_accept),
    .x     (w_x),
    .y     (w_y),
    .done  (w_core_done),
    .prod  (w_core_prod)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_prod  = r_rsp_prod;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Scoreboard bench for the shared Booth multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*W-1:0]       req_x;
  logic [NREQ*W-1:0]       req_y;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [2*W-1:0]          rsp_prod;
  logic                    busy;

  mul_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t           q[$];
  int             glog[$];
  int             n_checks = 0;
  int             n_errors = 0;
  int             n_acc    = 0;
  bit             m_idle   = 1'b1;
  int             m_rr     = 0;
  int             m_lat    = 0;
  int             last_id  = -1;
  logic [2*W-1:0] last_prod = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model of arbitration, latency and results, sampled mid-cycle
  int              mg;
  bit              mfound;
  int              midx;
  logic [NREQ-1:0] exp_ready;
  logic signed [2*W-1:0] mprod;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_idle = 1'b1;
      m_rr   = 0;
      m_lat  = 0;
    end else begin
      check("busy", 64'(busy), 64'(!m_idle));
      if (m_idle) begin
        mfound = 1'b0;
        mg     = 0;
        for (int i = 0; i < NREQ; i++) begin
          midx = (m_rr + i) % NREQ;
          if (!mfound && req_valid[midx]) begin
            mfound = 1'b1;
            mg     = midx;
          end
        end
        exp_ready = mfound ? (NREQ'(1) << mg) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        if (mfound) begin
          mprod = $signed(req_x[mg*W +: W]) * $signed(req_y[mg*W +: W]);
          q.push_back('{id: mg, prod: mprod});
          glog.push_back(mg);
          m_rr   = (mg + 1) % NREQ;
          m_idle = 1'b0;
          m_lat  = 0;
          n_acc++;
        end
      end else begin
        m_lat++;
        check("req_ready_busy", 64'(req_ready), 64'(0));
        check("rsp_valid_latency", 64'(rsp_valid), 64'(m_lat >= 9));
        if (rsp_valid && q.size() > 0) begin
          check("rsp_id", 64'(rsp_id), 64'(q[0].id));
          check("rsp_prod", 64'(rsp_prod), 64'(q[0].prod));
          if (rsp_ready) begin
            last_id   = q[0].id;
            last_prod = q[0].prod;
            void'(q.pop_front());
            m_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic set_ops(input int id, input int xv, input int yv);
    logic [31:0] xb, yb;
    xb = xv;
    yb = yv;
    req_x[id*W +: W] = xb[W-1:0];
    req_y[id*W +: W] = yb[W-1:0];
  endtask

  task automatic wait_accept(input int n0);
    bit got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk);
      if (n_acc != n0) got = 1'b1;
    end
    check("accept_timeout", 64'(got), 64'(1));
    #1;
  endtask

  task automatic issue(input int id, input int xv, input int yv, input bit scramble);
    int n0;
    n0 = n_acc;
    set_ops(id, xv, yv);
    req_valid[id] = 1'b1;
    wait_accept(n0);
    req_valid[id] = 1'b0;
    if (scramble) set_ops(id, int'($urandom), int'($urandom));
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(posedge clk);
      if (m_idle && q.size() == 0) got = 1'b1;
    end
    check("done_timeout", 64'(got), 64'(1));
    #1;
  endtask

  initial begin
    int             gs;
    int             n0;
    bit             got;
    logic [2*W-1:0] snap_prod;
    logic [1:0]     snap_id;

    reset     = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_prod", 64'(rsp_prod), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    @(posedge clk);
    #1;

    // Single request from requester 2
    issue(2, 3, -5, 1'b0);
    wait_done();
    check("single_id", 64'(last_id), 64'(2));
    check("single_prod", 64'(last_prod), 64'h0000_0000_FFFF_FFF1);

    // Corner operands
    issue(0, -32768, -32768, 1'b0);
    wait_done();
    check("corner_minmin", 64'(last_prod), 64'h0000_0000_4000_0000);
    issue(1, 32767, -32768, 1'b0);
    wait_done();
    check("corner_maxmin", 64'(last_prod), 64'h0000_0000_C000_8000);
    issue(3, 0, -1, 1'b0);
    wait_done();
    check("corner_zero", 64'(last_prod), 64'(0));

    // Operands scrambled right after accept
    issue(1, 1234, -77, 1'b1);
    wait_done();
    check("opchange_prod", 64'(last_prod), 64'h0000_0000_FFFE_8CD6);

    // Backpressure with a competing request waiting
    rsp_ready = 1'b0;
    issue(0, -300, 411, 1'b0);
    set_ops(2, 77, 88);
    req_valid[2] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) got = 1'b1;
    end
    check("bp_valid_timeout", 64'(got), 64'(1));
    snap_prod = rsp_prod;
    snap_id   = rsp_id;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(rsp_valid), 64'(1));
      check("bp_hold_prod", 64'(rsp_prod), 64'(snap_prod));
      check("bp_hold_id", 64'(rsp_id), 64'(snap_id));
      check("bp_ready_low", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    n0 = n_acc;
    rsp_ready = 1'b1;
    wait_accept(n0);
    req_valid[2] = 1'b0;
    wait_done();
    check("bp_second_id", 64'(last_id), 64'(2));

    // Reset in flight discards the operation
    issue(3, 500, 600, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy_low", 64'(busy), 64'(0));
    check("rst_no_valid", 64'(rsp_valid), 64'(0));
    repeat (12) @(posedge clk);
    #1;

    // All requesters valid: strict rotation from requester 0
    gs = glog.size();
    n0 = n_acc;
    for (int i = 0; i < NREQ; i++) set_ops(i, 100 * (i + 1) - 7, -(31 * i) - 3);
    req_valid = '1;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk);
      if (n_acc >= n0 + 5) got = 1'b1;
    end
    check("rr_timeout", 64'(got), 64'(1));
    #1 req_valid = '0;
    wait_done();
    for (int k = 0; k < 5; k++) begin
      check("rr_order", 64'((gs + k < glog.size()) ? glog[gs + k] : -1), 64'(k % NREQ));
    end

    // Random single requests
    for (int r = 0; r < 6; r++) begin
      issue(int'($urandom_range(0, NREQ - 1)), int'($urandom), int'($urandom), 1'b1);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
